mdu_ctrl: RTL and testbench

- Multi-cycle multiply/divide unit with its sequencing controller, in the E stage of the P6 five-stage MIPS pipeline.
- Accepts a one-cycle `start` from E-stage decode and latches operands.
- Holds `busy` for a fixed latency, then commits the result to HI/LO.
- Generates the D-stage stall for MD-class instructions. `start` and `busy` are the signals that freeze and flush the ID/EX register.

---
 rtl/mdu_pkg.sv | 20 ++
 rtl/mdu_calc.sv | 74 +++++++
 rtl/mdu_ctrl.sv | 114 +++++++++++
 tb/tb_mdu_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: MD operation codes and FSM states.
package mdu_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6,
        MD_RSVD  = 3'd7
    } md_op_e;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } mdu_state_e;

endpackage

// File: rtl/mdu_calc.sv
// Combinational 64-bit result generator for mult/multu/div/divu, with divide-by-zero flag.
module mdu_calc
    import mdu_pkg::*;
(
    input  logic [2:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo,
    output logic        o_div_zero
);

    md_op_e             w_op;
    logic               w_b_zero;
    logic [31:0]        w_b_nz;
    logic signed [63:0] w_prod_s;
    logic [63:0]        w_prod_u;
    logic signed [32:0] w_a_s;
    logic signed [32:0] w_b_s;
    logic signed [32:0] w_quo_s;
    logic signed [32:0] w_rem_s;
    logic [31:0]        w_quo_u;
    logic [31:0]        w_rem_u;
    logic               w_unused_msb;

    assign w_op     = md_op_e'(i_op);
    assign w_b_zero = (i_b == 32'd0);
    // Substitute a divisor of 1 so the dividers never see zero; the result is discarded anyway.
    assign w_b_nz   = w_b_zero ? 32'd1 : i_b;

    assign w_prod_s = $signed({{32{i_a[31]}}, i_a}) * $signed({{32{i_b[31]}}, i_b});
    assign w_prod_u = {32'd0, i_a} * {32'd0, i_b};

    // 33-bit signed divide so 0x80000000 / -1 yields +2^31, whose low word is 0x80000000.
    assign w_a_s   = $signed({i_a[31], i_a});
    assign w_b_s   = $signed({w_b_nz[31], w_b_nz});
    assign w_quo_s = w_a_s / w_b_s;
    assign w_rem_s = w_a_s % w_b_s;
    assign w_quo_u = i_a / w_b_nz;
    assign w_rem_u = i_a % w_b_nz;

    assign w_unused_msb = w_quo_s[32] ^ w_rem_s[32];

    always_comb begin
        o_hi       = 32'd0;
        o_lo       = 32'd0;
        o_div_zero = 1'b0;
        case (w_op)
            MD_MULT: begin
                o_hi = w_prod_s[63:32];
                o_lo = w_prod_s[31:0];
            end
            MD_MULTU: begin
                o_hi = w_prod_u[63:32];
                o_lo = w_prod_u[31:0];
            end
            MD_DIV: begin
                o_hi       = w_rem_s[31:0];
                o_lo       = w_quo_s[31:0];
                o_div_zero = w_b_zero;
            end
            MD_DIVU: begin
                o_hi       = w_rem_u;
                o_lo       = w_quo_u;
                o_div_zero = w_b_zero;
            end
            default: begin
                o_hi = 32'd0;
                o_lo = 32'd0;
            end
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// E-stage multiply/divide unit: fixed-latency sequencer, HI/LO registers and D-stage stall.
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10,
    parameter int unsigned CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_E,
    input  logic [31:0] rt_E,
    input  logic        md_D,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        stall_md
);

    mdu_state_e       r_state, w_state_d;
    logic [CNT_W-1:0] r_cnt, w_cnt_d;
    logic [31:0]      r_hi, w_hi_d;
    logic [31:0]      r_lo, w_lo_d;
    logic [31:0]      r_pend_hi, w_pend_hi_d;
    logic [31:0]      r_pend_lo, w_pend_lo_d;
    logic             r_pend_ok, w_pend_ok_d;

    md_op_e      w_op;
    logic        w_is_md;
    logic        w_is_div;
    logic [31:0] w_calc_hi;
    logic [31:0] w_calc_lo;
    logic        w_div_zero;

    assign w_op     = md_op_e'(md_op);
    assign w_is_md  = (w_op == MD_MULT) || (w_op == MD_MULTU) ||
                      (w_op == MD_DIV)  || (w_op == MD_DIVU);
    assign w_is_div = (w_op == MD_DIV)  || (w_op == MD_DIVU);

    mdu_calc u_calc (
        .i_op       (md_op),
        .i_a        (rs_E),
        .i_b        (rt_E),
        .o_hi       (w_calc_hi),
        .o_lo       (w_calc_lo),
        .o_div_zero (w_div_zero)
    );

    always_comb begin
        w_state_d   = r_state;
        w_cnt_d     = r_cnt;
        w_hi_d      = r_hi;
        w_lo_d      = r_lo;
        w_pend_hi_d = r_pend_hi;
        w_pend_lo_d = r_pend_lo;
        w_pend_ok_d = r_pend_ok;
        case (r_state)
            S_IDLE: begin
                if (start && w_is_md) begin
                    w_state_d   = S_RUN;
                    w_cnt_d     = w_is_div ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);
                    w_pend_hi_d = w_calc_hi;
                    w_pend_lo_d = w_calc_lo;
                    w_pend_ok_d = !w_div_zero;
                end else if (w_op == MD_MTHI) begin
                    w_hi_d = rs_E;
                end else if (w_op == MD_MTLO) begin
                    w_lo_d = rs_E;
                end
            end
            S_RUN: begin
                // New starts and mthi/mtlo are ignored here; the stall keeps them out.
                if (r_cnt == '0) begin
                    w_state_d = S_IDLE;
                    if (r_pend_ok) begin
                        w_hi_d = r_pend_hi;
                        w_lo_d = r_pend_lo;
                    end
                end else begin
                    w_cnt_d = r_cnt - 1'b1;
                end
            end
            default: w_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_pend_hi <= 32'd0;
            r_pend_lo <= 32'd0;
            r_pend_ok <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_cnt     <= w_cnt_d;
            r_hi      <= w_hi_d;
            r_lo      <= w_lo_d;
            r_pend_hi <= w_pend_hi_d;
            r_pend_lo <= w_pend_lo_d;
            r_pend_ok <= w_pend_ok_d;
        end
    end

    assign busy     = (r_state == S_RUN);
    assign hi       = r_hi;
    assign lo       = r_lo;
    assign stall_md = md_D & (start | busy);

endmodule

// File: tb/tb_mdu_ctrl.sv
// Randomized self-checking bench for mdu_ctrl against an arithmetic reference model.
module tb_mdu_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] rs_E;
    logic [31:0] rt_E;
    logic        md_D;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        stall_md;

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_hi;
    logic [31:0] m_lo;

    mdu_ctrl #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10),
        .CNT_W       (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .md_op    (md_op),
        .rs_E     (rs_E),
        .rt_E     (rt_E),
        .md_D     (md_D),
        .busy     (busy),
        .hi       (hi),
        .lo       (lo),
        .stall_md (stall_md)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int latency(input logic [2:0] op);
        return (op == 3'd1 || op == 3'd2) ? 5 : 10;
    endfunction

    // Architectural effect of one MD operation on HI/LO.
    task automatic model_apply(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa;
        longint          sb;
        longint          p;
        longint unsigned pu;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'd1: begin
                p    = sa * sb;
                m_hi = p[63:32];
                m_lo = p[31:0];
            end
            3'd2: begin
                pu   = longint'(a) * longint'(b);
                m_hi = pu[63:32];
                m_lo = pu[31:0];
            end
            3'd3: if (b != 0) begin
                p    = sa / sb;
                m_lo = p[31:0];
                p    = sa % sb;
                m_hi = p[31:0];
            end
            3'd4: if (b != 0) begin
                m_lo = a / b;
                m_hi = a % b;
            end
            3'd5: m_hi = a;
            3'd6: m_lo = a;
            default: ;
        endcase
    endtask

    // Issue one mult/div; noise on start/md_op/operands during RUN must have no effect.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic d, input string name);
        int          n;
        logic [31:0] old_hi;
        logic [31:0] old_lo;
        old_hi = m_hi;
        old_lo = m_lo;
        md_D  = d;
        start = 1'b1;
        md_op = op;
        rs_E  = a;
        rt_E  = b;
        #1;
        checks++;
        if (stall_md !== d) begin
            failures++;
            $display("FAIL %s stall_at_start: got %b expected %b", name, stall_md, d);
        end
        tick();
        model_apply(op, a, b);
        n = 0;
        start = 1'b0;
        md_op = 3'd0;
        while (busy === 1'b1 && n < 20) begin
            checks++;
            if (stall_md !== d || hi !== old_hi || lo !== old_lo) begin
                failures++;
                $display("FAIL %s during_busy: stall=%b hi=%h lo=%h expected stall=%b hi=%h lo=%h",
                         name, stall_md, hi, lo, d, old_hi, old_lo);
            end
            start = 1'($urandom_range(0, 1));
            md_op = 3'($urandom_range(0, 7));
            rs_E  = $urandom;
            rt_E  = $urandom;
            n++;
            tick();
            start = 1'b0;
            md_op = 3'd0;
        end
        #1;
        checks++;
        if (n != latency(op)) begin
            failures++;
            $display("FAIL %s busy_len: got %0d expected %0d", name, n, latency(op));
        end
        checks++;
        if (stall_md !== 1'b0) begin
            failures++;
            $display("FAIL %s stall_after: got %b expected 0", name, stall_md);
        end
        checks++;
        if (hi !== m_hi || lo !== m_lo) begin
            failures++;
            $display("FAIL %s result: got hi=%h lo=%h expected hi=%h lo=%h", name, hi, lo, m_hi, m_lo);
        end
    endtask

    task automatic set_hilo(input logic [2:0] op, input logic [31:0] val);
        start = 1'b0;
        md_op = op;
        rs_E  = val;
        tick();
        md_op = 3'd0;
        model_apply(op, val, 32'd0);
        checks++;
        if (busy !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
            failures++;
            $display("FAIL mthi_mtlo: got busy=%b hi=%h lo=%h expected busy=0 hi=%h lo=%h",
                     busy, hi, lo, m_hi, m_lo);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        md_op = 3'd0;
        rs_E  = 32'd0;
        rt_E  = 32'd0;
        md_D  = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        m_hi  = 32'd0;
        m_lo  = 32'd0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || stall_md !== 1'b0) begin
                failures++;
                $display("FAIL reset_idle: got busy=%b hi=%h lo=%h stall=%b expected all zero",
                         busy, hi, lo, stall_md);
            end
            tick();
        end
    endtask

    task automatic test_mult();
        run_op(3'd1, 32'hFFFFFFFF, 32'd3, 1'b0, "mult");
        checks++;
        if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin
            failures++;
            $display("FAIL mult_const: got hi=%h lo=%h expected hi=ffffffff lo=fffffffd", hi, lo);
        end
        run_op(3'd2, 32'hFFFFFFFF, 32'd3, 1'b0, "multu");
        checks++;
        if (hi !== 32'h00000002 || lo !== 32'hFFFFFFFD) begin
            failures++;
            $display("FAIL multu_const: got hi=%h lo=%h expected hi=00000002 lo=fffffffd", hi, lo);
        end
    endtask

    task automatic test_div();
        run_op(3'd3, 32'hFFFFFFF9, 32'd2, 1'b0, "div");
        checks++;
        if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin
            failures++;
            $display("FAIL div_const: got hi=%h lo=%h expected hi=ffffffff lo=fffffffd", hi, lo);
        end
        run_op(3'd4, 32'd7, 32'd2, 1'b0, "divu");
        checks++;
        if (hi !== 32'd1 || lo !== 32'd3) begin
            failures++;
            $display("FAIL divu_const: got hi=%h lo=%h expected hi=00000001 lo=00000003", hi, lo);
        end
        run_op(3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, "div_ovf");
        checks++;
        if (hi !== 32'd0 || lo !== 32'h80000000) begin
            failures++;
            $display("FAIL div_ovf_const: got hi=%h lo=%h expected hi=00000000 lo=80000000", hi, lo);
        end
    endtask

    task automatic test_div_zero();
        set_hilo(3'd5, 32'h11);
        set_hilo(3'd6, 32'h22);
        run_op(3'd3, 32'h1234, 32'd0, 1'b0, "div_zero");
        checks++;
        if (hi !== 32'h11 || lo !== 32'h22) begin
            failures++;
            $display("FAIL div_zero_keep: got hi=%h lo=%h expected hi=00000011 lo=00000022", hi, lo);
        end
        run_op(3'd4, 32'hDEAD, 32'd0, 1'b0, "divu_zero");
    endtask

    task automatic test_stall();
        md_D  = 1'b1;
        start = 1'b0;
        md_op = 3'd0;
        #1;
        checks++;
        if (stall_md !== 1'b0) begin
            failures++;
            $display("FAIL stall_idle: got %b expected 0", stall_md);
        end
        run_op(3'd1, 32'd6, 32'd7, 1'b1, "stall_mult");
        run_op(3'd3, 32'd100, 32'd9, 1'b0, "nostall_div");
    endtask

    task automatic test_reset_midrun();
        set_hilo(3'd5, 32'h55);
        set_hilo(3'd6, 32'h66);
        start = 1'b1;
        md_op = 3'd3;
        rs_E  = 32'd100;
        rt_E  = 32'd7;
        tick();
        start = 1'b0;
        md_op = 3'd0;
        tick();
        tick();
        tick();
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL midrun_busy: got %b expected 1", busy);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_hi  = 32'd0;
        m_lo  = 32'd0;
        checks++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            failures++;
            $display("FAIL midrun_reset: got busy=%b hi=%h lo=%h expected all zero", busy, hi, lo);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
                failures++;
                $display("FAIL midrun_late_commit: got busy=%b hi=%h lo=%h expected all zero",
                         busy, hi, lo);
            end
        end
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'h80000000;
            2:       return 32'hFFFFFFFF;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(1, 6));
            a  = pick_operand();
            b  = pick_operand();
            if (op >= 3'd5) set_hilo(op, a);
            else            run_op(op, a, b, 1'($urandom_range(0, 1)), "random");
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_stall();
        test_reset_midrun();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
